// File: rtl/approx_eval_pkg.sv
// Shared state type and width helpers for the approximate-arithmetic error monitors.
package approx_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int sum_w(input int width);
        return width + 1;
    endfunction

    function automatic int idx_w(input int width);
        return 2 * width;
    endfunction

    function automatic int cnt_w(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int esum_w(input int width);
        return 3 * width + 1;
    endfunction

endpackage

// File: rtl/approx_err_accum.sv
// Error stage (registered |exact - dut_o|) followed by the accumulate stage that builds
// error sum, worst-case error and erroneous-pair count.
module approx_err_accum
    import approx_eval_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      flush,
    input  logic                      vld,
    input  logic [WIDTH:0]            exact,
    input  logic [WIDTH:0]            dut_o,
    output logic                      busy,
    output logic [esum_w(WIDTH)-1:0]  err_sum,
    output logic [WIDTH:0]            wce,
    output logic [cnt_w(WIDTH)-1:0]   err_cnt
);

    localparam int SW  = sum_w(WIDTH);
    localparam int ESW = esum_w(WIDTH);
    localparam int CW  = cnt_w(WIDTH);

    logic signed [SW:0]  w_diff;
    logic signed [SW:0]  w_neg;
    logic [SW-1:0]       w_mag;
    logic                r_e_vld;
    logic [SW-1:0]       r_d;
    logic [ESW-1:0]      r_err_sum;
    logic [SW-1:0]       r_wce;
    logic [CW-1:0]       r_err_cnt;

    // One extra bit keeps the difference signed; the magnitude always fits back in SW bits.
    assign w_diff = $signed({1'b0, exact}) - $signed({1'b0, dut_o});
    assign w_neg  = -w_diff;
    assign w_mag  = w_diff[SW] ? w_neg[SW-1:0] : w_diff[SW-1:0];

    // NOTE: non-blocking assignments let stage C see the d value registered on the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_vld <= 1'b0;
            r_d     <= '0;
        end else begin
            r_e_vld <= (clear || flush) ? 1'b0 : vld;
            r_d     <= w_mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sum <= '0;
            r_wce     <= '0;
            r_err_cnt <= '0;
        end else if (clear) begin
            r_err_sum <= '0;
            r_wce     <= '0;
            r_err_cnt <= '0;
        end else if (r_e_vld) begin
            r_err_sum <= r_err_sum + ESW'(r_d);
            if (r_d > r_wce) r_wce <= r_d;
            r_err_cnt <= r_err_cnt + CW'(r_d != '0);
        end
    end

    assign busy    = r_e_vld;
    assign err_sum = r_err_sum;
    assign wce     = r_wce;
    assign err_cnt = r_err_cnt;

endmodule

// File: rtl/add8u_err_monitor.sv
// Exhaustive error characteriser for WIDTH-bit approximate adders: sweeps every (A,B) pair,
// aligns the exact sum with the DUT latency and accumulates MAE/WCE/EP statistics.
module add8u_err_monitor
    import approx_eval_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DUT_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [WIDTH-1:0]      dut_a,
    output logic [WIDTH-1:0]      dut_b,
    input  logic [WIDTH:0]        dut_o,
    output logic                  busy,
    output logic                  done,
    output logic [3*WIDTH:0]      err_sum,
    output logic [WIDTH:0]        wce,
    output logic [2*WIDTH:0]      err_cnt
);

    localparam int SW = sum_w(WIDTH);
    localparam int IW = idx_w(WIDTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [WIDTH-1:0] r_dut_a;
    logic [WIDTH-1:0] r_dut_b;
    logic            r_issue_vld;

    logic            w_running;
    logic            w_start_ok;
    logic            w_abort_ok;
    logic            w_issue;
    logic            w_pipe_busy;
    logic [SW-1:0]   w_exact;
    logic [SW-1:0]   w_smp_exact;
    logic            w_smp_vld;
    logic            w_dly_busy;
    logic            w_acc_busy;

    assign w_running   = (r_state == RUN) || (r_state == DRAIN);
    assign w_start_ok  = start && !abort && !w_running;
    assign w_abort_ok  = abort && w_running;
    assign w_issue     = (r_state == RUN) && !abort;
    assign w_pipe_busy = r_issue_vld || w_dly_busy || w_acc_busy;

    // NOTE: the next state gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (w_start_ok) w_state_nxt = RUN;
            RUN: begin
                if (abort)             w_state_nxt = IDLE;
                else if (r_idx == '1)  w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)             w_state_nxt = IDLE;
                else if (!w_pipe_busy) w_state_nxt = DONE;
            end
            default:                   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Operands hold their last values outside RUN; idx wraps to 0 after the final pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_dut_a     <= '0;
            r_dut_b     <= '0;
            r_issue_vld <= 1'b0;
        end else begin
            r_issue_vld <= w_issue;
            if (w_start_ok) begin
                r_idx <= '0;
            end else if (w_issue) begin
                r_dut_a <= r_idx[WIDTH-1:0];
                r_dut_b <= r_idx[IW-1:WIDTH];
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    assign w_exact = SW'(r_dut_a) + SW'(r_dut_b);

    generate
        if (DUT_LAT == 0) begin : g_no_dly
            assign w_smp_vld   = r_issue_vld;
            assign w_smp_exact = w_exact;
            assign w_dly_busy  = 1'b0;
        end else begin : g_dly
            logic [DUT_LAT-1:0] r_vld_dly;
            logic [SW-1:0]      r_exact_dly [DUT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld_dly <= '0;
                end else if (w_abort_ok) begin
                    r_vld_dly <= '0;
                end else begin
                    r_vld_dly[0] <= r_issue_vld;
                    for (int i = 1; i < DUT_LAT; i++) r_vld_dly[i] <= r_vld_dly[i-1];
                end
            end

            // NOTE: only the valid bits need reset; exact-sum data is ignored while its valid is low.
            always_ff @(posedge clk) begin
                r_exact_dly[0] <= w_exact;
                for (int i = 1; i < DUT_LAT; i++) r_exact_dly[i] <= r_exact_dly[i-1];
            end

            assign w_smp_vld   = r_vld_dly[DUT_LAT-1];
            assign w_smp_exact = r_exact_dly[DUT_LAT-1];
            assign w_dly_busy  = |r_vld_dly;
        end
    endgenerate

    approx_err_accum #(
        .WIDTH (WIDTH)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_start_ok),
        .flush   (w_abort_ok),
        .vld     (w_smp_vld),
        .exact   (w_smp_exact),
        .dut_o   (dut_o),
        .busy    (w_acc_busy),
        .err_sum (err_sum),
        .wce     (wce),
        .err_cnt (err_cnt)
    );

    assign dut_a = r_dut_a;
    assign dut_b = r_dut_b;
    assign busy  = w_running;
    assign done  = (r_state == DONE);

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Runs five 8-bit monitors side by side against different adders, then exercises abort,
// restart and asynchronous reset on a 4-bit monitor with a randomized registered adder.
module tb_add8u_err_monitor;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic start8, abort8, start4, abort4;

    logic [7:0]  a8    [NI];
    logic [7:0]  b8    [NI];
    logic [8:0]  o8    [NI];
    logic        busy8 [NI];
    logic        done8 [NI];
    logic [24:0] sum8  [NI];
    logic [8:0]  wce8  [NI];
    logic [16:0] cnt8  [NI];
    logic [8:0]  lut8  [65536];
    logic [8:0]  r3_p, r3_q;

    logic [3:0]  a4, b4;
    logic [4:0]  o4;
    logic [4:0]  lut4 [256];
    logic        busy4, done4;
    logic [12:0] sum4;
    logic [4:0]  wce4;
    logic [8:0]  cnt4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance 3 has a 2-stage DUT; the others are combinational.
    for (genvar g = 0; g < NI; g++) begin : g_w8
        add8u_err_monitor #(.WIDTH(8), .DUT_LAT((g == 3) ? 2 : 0)) u_mon (
            .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
            .dut_a(a8[g]), .dut_b(b8[g]), .dut_o(o8[g]),
            .busy(busy8[g]), .done(done8[g]),
            .err_sum(sum8[g]), .wce(wce8[g]), .err_cnt(cnt8[g])
        );
    end

    assign o8[0] = 9'(a8[0]) + 9'(b8[0]);
    assign o8[1] = 9'(a8[1]) + 9'(b8[1]) + 9'd1;
    assign o8[2] = 9'd0;
    assign o8[3] = r3_q;
    assign o8[4] = lut8[{b8[4], a8[4]}];

    always_ff @(posedge clk) begin
        r3_p <= 9'(a8[3]) + 9'(b8[3]);
        r3_q <= r3_p;
    end

    add8u_err_monitor #(.WIDTH(4), .DUT_LAT(1)) u_mon4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .dut_a(a4), .dut_b(b4), .dut_o(o4),
        .busy(busy4), .done(done4),
        .err_sum(sum4), .wce(wce4), .err_cnt(cnt4)
    );

    always_ff @(posedge clk) o4 <= lut4[{b4, a4}];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random adders: roughly a quarter (8-bit) / half (4-bit) of the pairs get an arbitrary sum.
    task automatic fill8();
        for (int i = 0; i < 65536; i++) begin
            if ($urandom_range(0, 3) == 0) lut8[i] = 9'($urandom_range(0, 511));
            else                           lut8[i] = 9'((i % 256) + (i / 256));
        end
    endtask

    task automatic fill4();
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 0) lut4[i] = 5'($urandom_range(0, 31));
            else                           lut4[i] = 5'((i % 16) + (i / 16));
        end
    endtask

    task automatic model8(output longint s, output longint m, output longint c);
        s = 0; m = 0; c = 0;
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++) begin
                longint e = a + b;
                longint o = longint'(lut8[b * 256 + a]);
                longint d = (e >= o) ? e - o : o - e;
                s += d;
                if (d > m) m = d;
                if (d != 0) c++;
            end
    endtask

    task automatic model4(output longint s, output longint m, output longint c);
        s = 0; m = 0; c = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                longint e = a + b;
                longint o = longint'(lut4[b * 16 + a]);
                longint d = (e >= o) ? e - o : o - e;
                s += d;
                if (d > m) m = d;
                if (d != 0) c++;
            end
    endtask

    task automatic sweep4(output int cyc);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 1000) begin
            step();
            cyc++;
        end
    endtask

    task automatic check4(input string tag, input longint s, input longint m, input longint c);
        check({tag, "_sum"}, 64'(sum4), s);
        check({tag, "_wce"}, 64'(wce4), m);
        check({tag, "_cnt"}, 64'(cnt4), c);
    endtask

    initial begin
        longint es, em, ec;
        int n, t0, t3, cyc, k, saw_done;

        rst_n = 1'b0; start8 = 1'b0; abort8 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
        fill8();
        fill4();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy8", 64'(busy8[0]), 0);
        check("rst_done8", 64'(done8[0]), 0);
        check("rst_a8", 64'(a8[0]), 0);
        check("rst_sum4", 64'(sum4), 0);
        check("rst_cnt4", 64'(cnt4), 0);
        rst_n = 1'b1;
        step();

        // Full 8-bit sweep on all five monitors; a mid-run start must be ignored.
        model8(es, em, ec);
        start8 = 1'b1;
        step();
        n = 0; t0 = 0; t3 = 0;
        while (t3 == 0 && n < 70000) begin
            start8 = (n == 30000);
            step();
            n++;
            if (n == 100) begin
                check("run_busy8", 64'(busy8[0]), 1);
                check("run_done8", 64'(done8[0]), 0);
            end
            if (done8[0] && t0 == 0) t0 = n;
            if (done8[3] && t3 == 0) t3 = n;
        end
        start8 = 1'b0;
        check("len_lat0", 64'(t0), 65539);
        check("len_lat2", 64'(t3), 65541);
        check("exact_sum", 64'(sum8[0]), 0);
        check("exact_wce", 64'(wce8[0]), 0);
        check("exact_cnt", 64'(cnt8[0]), 0);
        check("off_sum", 64'(sum8[1]), 65536);
        check("off_wce", 64'(wce8[1]), 1);
        check("off_cnt", 64'(cnt8[1]), 65536);
        check("zero_sum", 64'(sum8[2]), 16711680);
        check("zero_wce", 64'(wce8[2]), 510);
        check("zero_cnt", 64'(cnt8[2]), 65535);
        check("lat2_sum", 64'(sum8[3]), 0);
        check("lat2_cnt", 64'(cnt8[3]), 0);
        check("rnd8_sum", 64'(sum8[4]), es);
        check("rnd8_wce", 64'(wce8[4]), em);
        check("rnd8_cnt", 64'(cnt8[4]), ec);
        check("done8_busy", 64'(busy8[0]), 0);

        // 4-bit randomized sweep, then operands must hold the last pair.
        model4(es, em, ec);
        sweep4(cyc);
        check("len4", 64'(cyc), 260);
        check4("rnd4a", es, em, ec);
        repeat (5) step();
        check("hold_a4", 64'(a4), 15);
        check("hold_b4", 64'(b4), 15);
        check("hold_done4", 64'(done4), 1);

        // Restart from DONE, abort (with start also high) at a random cycle.
        fill4();
        model4(es, em, ec);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        k = $urandom_range(5, 250);
        repeat (k) step();
        start4 = 1'b1; abort4 = 1'b1;
        step();
        start4 = 1'b0; abort4 = 1'b0;
        check("abort_busy4", 64'(busy4), 0);
        check("abort_done4", 64'(done4), 0);
        saw_done = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (done4) saw_done = 1;
        end
        check("abort_no_done", 64'(saw_done), 0);
        start4 = 1'b1; abort4 = 1'b1;
        step();
        start4 = 1'b0; abort4 = 1'b0;
        check("idle_abort_wins", 64'(busy4), 0);
        sweep4(cyc);
        check("len4_after_abort", 64'(cyc), 260);
        check4("rnd4b", es, em, ec);

        // Asynchronous reset in the middle of a sweep.
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (50) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy4", 64'(busy4), 0);
        check("arst_a4", 64'(a4), 0);
        check4("arst", 0, 0, 0);
        check("arst_sum8", 64'(sum8[1]), 0);
        check("arst_done8", 64'(done8[1]), 0);
        start4 = 1'b1;
        repeat (3) step();
        check("arst_start_ignored", 64'(busy4), 0);
        start4 = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("post_rst_busy4", 64'(busy4), 0);
        sweep4(cyc);
        check("len4_after_rst", 64'(cyc), 260);
        check4("rnd4c", es, em, ec);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
